// File: rtl/addsub_serial_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side is the arithmetic unit.
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ctrl;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, ctrl, cin, a, b,
    input  busy, done, s, cout, ovf, zero
  );

  modport slave (
    input  start, ctrl, cin, a, b,
    output busy, done, s, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Bit-serial adder/subtractor: BPC bits per clock, LSB first, with a
// registered carry/borrow chained across cycles. Results are published
// only when the operation completes and then held until the next one.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input logic           clk,
  input logic           rst_n,
  addsub_serial_if.slave bus
);
  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic               ctrl_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r;
  logic               ovf_r;
  logic               zero_r;

  logic [BPC-1:0]     chunk_s;
  logic               c_s;
  logic               c_last_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic [1:0]         step_s;

  // One full-adder / full-subtractor bit: returns {carry_or_borrow, sum_or_diff}.
  function automatic logic [1:0] bit_step(input logic sub, input logic ai,
                                          input logic bi, input logic ci);
    logic co;
    if (sub) begin
      co = (~ai & bi) | (~ai & ci) | (bi & ci);
    end else begin
      co = (ai & bi) | (ci & (ai ^ bi));
    end
    return {co, ai ^ bi ^ ci};
  endfunction

  // Ripple through the current BPC-bit slice; remember the carry entering its top bit.
  always_comb begin
    c_s      = carry_r;
    c_last_s = carry_r;
    chunk_s  = '0;
    step_s   = 2'b00;
    for (int i = 0; i < BPC; i++) begin
      c_last_s   = c_s;
      step_s     = bit_step(ctrl_r, a_r[i], b_r[i], c_s);
      chunk_s[i] = step_s[0];
      c_s        = step_s[1];
    end
    acc_next_s = WIDTH'({chunk_s, acc_r} >> BPC);
  end

  // Control FSM plus datapath registers; outputs change only on entry to DONE.
  // The edge leaving DONE also samples start, so a held start gives one
  // operation every N+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      ctrl_r  <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            ctrl_r  <= bus.ctrl;
            carry_r <= bus.cin;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> BPC;
          b_r     <= b_r >> BPC;
          acc_r   <= acc_next_s;
          carry_r <= c_s;
          if (cnt_r == CNT_W'(N - 1)) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            s_r     <= acc_next_s;
            cout_r  <= c_s;
            ovf_r   <= c_last_s ^ c_s;
            zero_r  <= (acc_next_s == '0);
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
  assign bus.zero = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: two instances (8-bit/1 bit per clock
// and 16-bit/4 bits per clock) driven with directed and random operations.
module tb_addsub_serial;
  localparam int NN0 = 8;
  localparam int NN1 = 4;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   ww[2];
  int   nn[2];
  int   next_free[2];
  exp_t q[2][$];
  exp_t last[2];

  logic        dst[2];
  logic        dsub[2];
  logic        dcin[2];
  logic [15:0] da[2];
  logic [15:0] db[2];

  logic [15:0] os[2];
  logic        ob[2], od[2], oc[2], oo[2], oz[2];

  addsub_serial_if #(.WIDTH(8))  bus0 ();
  addsub_serial_if #(.WIDTH(16)) bus1 ();

  addsub_serial #(.WIDTH(8), .BPC(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  addsub_serial #(.WIDTH(16), .BPC(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.start = dst[0];
  assign bus0.ctrl  = dsub[0];
  assign bus0.cin   = dcin[0];
  assign bus0.a     = da[0][7:0];
  assign bus0.b     = db[0][7:0];
  assign bus1.start = dst[1];
  assign bus1.ctrl  = dsub[1];
  assign bus1.cin   = dcin[1];
  assign bus1.a     = da[1];
  assign bus1.b     = db[1];

  assign os[0] = {8'h00, bus0.s};
  assign ob[0] = bus0.busy;
  assign od[0] = bus0.done;
  assign oc[0] = bus0.cout;
  assign oo[0] = bus0.ovf;
  assign oz[0] = bus0.zero;
  assign os[1] = bus1.s;
  assign ob[1] = bus1.busy;
  assign od[1] = bus1.done;
  assign oc[1] = bus1.cout;
  assign oo[1] = bus1.ovf;
  assign oz[1] = bus1.zero;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, unsigned for s/cout, signed range for ovf.
  function automatic exp_t ref_op(int w, bit sub, bit cin, int ua, int ub);
    exp_t e;
    int mod, half, full, sa, sb, sr;
    mod  = 1 << w;
    half = mod / 2;
    if (!sub) begin
      full   = ua + ub + int'(cin);
      e.cout = (full >= mod);
      full   = full % mod;
    end else begin
      full   = ua - ub - int'(cin);
      e.cout = (full < 0);
      full   = (full + mod) % mod;
    end
    e.s    = 16'(full);
    sa     = (ua >= half) ? ua - mod : ua;
    sb     = (ub >= half) ? ub - mod : ub;
    sr     = sub ? (sa - sb - int'(cin)) : (sa + sb + int'(cin));
    e.ovf  = (sr > half - 1) || (sr < -half);
    e.zero = (full == 0);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic chk(string name, int i, logic [15:0] act, logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", name, i, cyc, act, want);
    end
  endtask

  // Monitor: pop the scoreboard when a done is due, otherwise check outputs hold.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic eb, ed;
      exp_t h;
      eb = 1'b0;
      ed = 1'b0;
      h  = last[i];
      if (q[i].size() > 0) begin
        h  = q[i][0];
        eb = (cyc >= h.done_cyc - nn[i]) && (cyc < h.done_cyc);
        ed = (cyc == h.done_cyc);
      end
      chk("busy", i, {15'd0, ob[i]}, {15'd0, eb});
      chk("done", i, {15'd0, od[i]}, {15'd0, ed});
      if (ed) begin
        void'(q[i].pop_front());
        last[i] = h;
      end
      chk("s",    i, os[i], last[i].s);
      chk("cout", i, {15'd0, oc[i]}, {15'd0, last[i].cout});
      chk("ovf",  i, {15'd0, oo[i]}, {15'd0, last[i].ovf});
      chk("zero", i, {15'd0, oz[i]}, {15'd0, last[i].zero});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one instance for the coming edge; record an expectation if the
  // model says that edge accepts the request.
  task automatic issue(int i, bit st, bit sub, bit cin, int a, int b);
    int mask;
    exp_t e;
    mask    = (1 << ww[i]) - 1;
    dst[i]  = st;
    dsub[i] = sub;
    dcin[i] = cin;
    da[i]   = 16'(a & mask);
    db[i]   = 16'(b & mask);
    if (st && rst_n && (cyc + 1 >= next_free[i])) begin
      e = ref_op(ww[i], sub, cin, a & mask, b & mask);
      e.done_cyc = cyc + 1 + nn[i];
      q[i].push_back(e);
      next_free[i] = cyc + 1 + nn[i] + 1;
    end
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) begin
      issue(0, 1'b0, 1'b0, 1'b0, 0, 0);
      issue(1, 1'b0, 1'b0, 1'b0, 0, 0);
      tick();
    end
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      last[i] = '{s: 16'h0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0, done_cyc: 0};
      dst[i] = 1'b0;
    end
    for (int j = 0; j < hold; j++) tick();
    rst_n = 1'b1;
    next_free[0] = cyc + 1;
    next_free[1] = cyc + 1;
  endtask

  initial begin
    ww[0] = 8;   nn[0] = NN0;
    ww[1] = 16;  nn[1] = NN1;
    for (int i = 0; i < 2; i++) begin
      dst[i] = 1'b0; dsub[i] = 1'b0; dcin[i] = 1'b0; da[i] = 16'h0000; db[i] = 16'h0000;
      next_free[i] = 0;
      last[i] = '{s: 16'h0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0, done_cyc: 0};
    end
    #2;
    do_reset(3);

    // Directed corner vectors.
    issue(0, 1'b1, 1'b0, 1'b0, 'h7F, 'h01);
    issue(1, 1'b1, 1'b0, 1'b0, 'hFFFF, 'h0001);
    tick();
    idle(NN0 + 1);
    issue(0, 1'b1, 1'b0, 1'b0, 'hFF, 'h01);
    issue(1, 1'b1, 1'b1, 1'b0, 'h8000, 'h0001);
    tick(); idle(NN0 + 1);
    issue(0, 1'b1, 1'b0, 1'b1, 'h10, 'h20);
    issue(1, 1'b1, 1'b1, 1'b1, 'h0000, 'h0000);
    tick(); idle(NN0 + 1);
    issue(0, 1'b1, 1'b1, 1'b0, 'h05, 'h07);
    issue(1, 1'b0, 1'b0, 1'b0, 0, 0);
    tick(); idle(NN0 + 1);
    issue(0, 1'b1, 1'b1, 1'b0, 'h80, 'h01);
    tick(); idle(NN0 + 1);

    // Operand capture and ignored restarts: accepted at edge k, pokes at k+3 and k+8, new op at k+9.
    issue(0, 1'b1, 1'b0, 1'b0, 'h3C, 'h5A);
    tick();
    for (int j = 0; j < 9; j++) begin
      issue(0, (j == 2 || j == 7 || j == 8), 1'b1, 1'b1, 'hA0 + j, 'h11 * j);
      issue(1, 1'b0, 1'b0, 1'b0, 0, 0);
      tick();
    end
    idle(NN0 + 2);

    // Reset in the middle of a run: low across edge k+4, no done afterwards.
    issue(0, 1'b1, 1'b0, 1'b0, 'h12, 'h34);
    issue(1, 1'b1, 1'b0, 1'b0, 'h1234, 'h4321);
    tick();
    idle(3);
    do_reset(2);
    idle(10);

    // Random traffic, start asserted about three cycles in four.
    for (int j = 0; j < 300; j++) begin
      for (int i = 0; i < 2; i++)
        issue(i, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF));
      tick();
    end

    // Start held high continuously: back-to-back operations.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 2; i++)
        issue(i, 1'b1, 1'($urandom), 1'($urandom),
              int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF));
      tick();
    end
    idle(NN0 + 4);

    for (int i = 0; i < 2; i++) chk("drain", i, 16'(q[i].size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 8; operand/result width in bits, SHALL be >= 2.
REQ-002 Parameter BPC, default 1; bits processed per clock, SHALL divide WIDTH exactly; N = WIDTH/BPC.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request new operation; sampled only in IDLE.
REQ-006 ctrl  input  1  mode: 0 = add, 1 = subtract.
REQ-007 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 busy  output  1  high while operation in progress.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 s  output  WIDTH  result.
REQ-013 cout  output  1  carry-out (add) / borrow-out (subtract).
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  high when s == 0.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after N RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 On the accepting edge (start=1 in IDLE), a, b, ctrl, cin SHALL be captured internally; later input changes SHALL NOT affect the operation.
REQ-018 Each RUN cycle processes BPC bits LSB-first, chaining carry/borrow internally across cycles via a registered carry bit.
REQ-019 Add bit rule: sum = a^b^c; carry = a&b | c&(a^b).
REQ-020 Subtract bit rule: diff = a^b^c; borrow = ~a&b | ~a&c | b&c; result equals (a - b - cin) mod 2^WIDTH.
REQ-021 ovf SHALL equal carry/borrow into the MSB XOR carry/borrow out of the MSB, in both modes.
REQ-022 If start accepted at edge k: busy=1 from edge k through edge k+N-1 inclusive; at edge k+N state=DONE, busy=0, done=1; at edge k+N+1 done=0, state=IDLE.
REQ-023 s, cout, ovf, zero SHALL update only at the edge entering DONE and hold until the next such edge; no partial results visible.
REQ-024 start while in RUN or DONE SHALL be ignored (not queued); earliest new acceptance is edge k+N+1.
REQ-025 Back-to-back operation: start held high continuously yields one operation every N+1 cycles.
REQ-026 done and busy SHALL never be high simultaneously.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, zero=0, internal carry and counter 0, regardless of clock.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow; first start after release behaves as from power-up.

Verification (WIDTH=8, BPC=1 unless stated; start accepted at edge k)
REQ-029 add a=8'h7F b=8'h01 cin=0 -> at edge k+8: done=1, s=8'h80, cout=0, ovf=1, zero=0.
REQ-030 add a=8'hFF b=8'h01 cin=0 -> s=8'h00, cout=1, ovf=0, zero=1; also a=8'h10 b=8'h20 cin=1 -> s=8'h31, cout=0.
REQ-031 sub a=8'h05 b=8'h07 cin=0 -> s=8'hFE, cout=1, ovf=0; sub a=8'h80 b=8'h01 cin=0 -> s=8'h7F, cout=0, ovf=1.
REQ-032 start pulsed again at edges k+3 and k+8 with different operands -> ignored, single done at k+8 with original result; start at k+9 accepted.
REQ-033 rst_n low at edge k+4 of an operation -> outputs all 0 immediately, no done pulse in following 10 cycles with start=0.
REQ-034 WIDTH=16, BPC=4: add 16'hFFFF + 16'h0001 -> done at edge k+4, s=16'h0000, cout=1, zero=1, busy high exactly 4 cycles.
